// File: rtl/radix2_div.sv
// -----------------------------------------------------------------------------
// radix2_div
//   Iterative restoring radix-2 divider for 64-bit operands. Each operand can
//   be treated as signed (two's complement) or unsigned. A normal division
//   retires one quotient bit per cycle, so results appear 65 cycles after the
//   request is accepted. Division by zero and signed overflow bypass the
//   iteration and complete in one cycle.
//
// Ports
//   clk          single clock, rising-edge
//   rst          synchronous active-high reset
//   rs1_signed   dividend is two's complement when 1
//   rs2_signed   divisor is two's complement when 1
//   rs1_data     dividend
//   rs2_data     divisor
//   sel          start request, only looked at while idle
//   flush        abort the operation in progress (wins over sel)
//   busy         high whenever the divider is not idle
//   valid        one-cycle pulse when quot_result/rem_result are fresh
//   quot_result  quotient, held until the next completion
//   rem_result   remainder, held until the next completion
// -----------------------------------------------------------------------------
module radix2_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        rs1_signed,
  input  logic        rs2_signed,
  input  logic [63:0] rs1_data,
  input  logic [63:0] rs2_data,
  input  logic        sel,
  input  logic        flush,
  output logic        busy,
  output logic        valid,
  output logic [63:0] quot_result,
  output logic [63:0] rem_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  state_t       state_next;

  // {remainder, quotient} working register; the dividend magnitude starts in
  // the low half and is shifted into the remainder one bit per iteration.
  logic [127:0] rq;
  logic [63:0]  divisor;
  logic [5:0]   count;
  logic         quot_neg;
  logic         rem_neg;

  logic         rs1_neg;
  logic         rs2_neg;
  logic [63:0]  rs1_mag;
  logic [63:0]  rs2_mag;
  logic         div_zero;
  logic         overflow;
  logic         special;
  logic         start;
  logic         last_iter;
  logic [64:0]  trial;
  logic [127:0] step_rq;
  logic [63:0]  final_quot;
  logic [63:0]  final_rem;

  // Operand decode for the capture cycle: magnitudes, sign flags and the two
  // cases that skip the iterative loop.
  always_comb begin
    rs1_neg  = rs1_signed & rs1_data[63];
    rs2_neg  = rs2_signed & rs2_data[63];
    rs1_mag  = rs1_neg ? (~rs1_data + 64'd1) : rs1_data;
    rs2_mag  = rs2_neg ? (~rs2_data + 64'd1) : rs2_data;
    div_zero = (rs2_data == 64'd0);
    overflow = rs1_signed & rs2_signed &
               (rs1_data == 64'h8000_0000_0000_0000) &
               (rs2_data == 64'hFFFF_FFFF_FFFF_FFFF);
    special  = div_zero | overflow;
    start    = (state == IDLE) & sel & ~flush;
  end

  // One restoring step. The partial remainder before the shift is below the
  // divisor but may use bit 63, so the shifted value needs 65 bits. Bit 64 of
  // the 65-bit difference is set exactly when the subtraction would go
  // negative, in which case the shifted remainder is kept unchanged.
  always_comb begin
    last_iter = (count == 6'd63);
    trial     = rq[127:63] - {1'b0, divisor};
    if (trial[64]) begin
      step_rq = {rq[126:0], 1'b0};
    end else begin
      step_rq = {trial[63:0], rq[62:0], 1'b1};
    end
    final_quot = quot_neg ? (~step_rq[63:0] + 64'd1) : step_rq[63:0];
    final_rem  = rem_neg ? (~step_rq[127:64] + 64'd1) : step_rq[127:64];
  end

  // Next-state logic and status outputs. Flush from any state returns to
  // idle, which also drops a sel arriving in the same cycle.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    valid      = (state == DONE);
    case (state)
      IDLE: begin
        if (sel) begin
          state_next = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // State, datapath and result registers. Results are only written on entry
  // to DONE, so they stay put through flushes and idle periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rq          <= 128'd0;
      divisor     <= 64'd0;
      count       <= 6'd0;
      quot_neg    <= 1'b0;
      rem_neg     <= 1'b0;
      quot_result <= 64'd0;
      rem_result  <= 64'd0;
    end else begin
      state <= state_next;
      if (start) begin
        rq       <= {64'd0, rs1_mag};
        divisor  <= rs2_mag;
        quot_neg <= rs1_neg ^ rs2_neg;
        rem_neg  <= rs1_neg;
        count    <= 6'd0;
        if (div_zero) begin
          quot_result <= 64'hFFFF_FFFF_FFFF_FFFF;
          rem_result  <= rs1_data;
        end else if (overflow) begin
          quot_result <= rs1_data;
          rem_result  <= 64'd0;
        end
      end else if ((state == CALC) && !flush) begin
        rq    <= step_rq;
        count <= count + 6'd1;
        if (last_iter) begin
          quot_result <= final_quot;
          rem_result  <= final_rem;
        end
      end
    end
  end

endmodule

// File: tb/tb_radix2_div.sv
// -----------------------------------------------------------------------------
// tb_radix2_div
//   Scoreboard bench for radix2_div. Each accepted request pushes its expected
//   quotient, remainder and latency; a negedge monitor pops and compares on
//   every valid pulse. Expected values come from 65-bit signed division.
// -----------------------------------------------------------------------------
module tb_radix2_div;

  logic        clk;
  logic        rst;
  logic        rs1_signed;
  logic        rs2_signed;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        sel;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [63:0] quot_result;
  logic [63:0] rem_result;

  typedef struct {
    logic [63:0] quot;
    logic [63:0] rem;
    int          startCycle;
    int          latency;
    int          opId;
  } exp_t;

  exp_t sb[$];
  int   testsRun   = 0;
  int   failCount  = 0;
  int   cycleCount = 0;
  int   lastStart  = 0;
  int   opCounter  = 0;

  radix2_div dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_signed  (rs1_signed),
    .rs2_signed  (rs2_signed),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .sel         (sel),
    .flush       (flush),
    .busy        (busy),
    .valid       (valid),
    .quot_result (quot_result),
    .rem_result  (rem_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: during the cycle after the Nth rising edge this reads N.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Reference model using wide signed arithmetic on sign/zero-extended
  // operands, with the two one-cycle special cases.
  function automatic exp_t computeExpected(input logic s1, input logic s2,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
    exp_t e;
    logic signed [64:0] sa;
    logic signed [64:0] sbv;
    logic signed [64:0] q65;
    logic signed [64:0] r65;
    sa  = s1 ? {a[63], a} : {1'b0, a};
    sbv = s2 ? {b[63], b} : {1'b0, b};
    e.startCycle = 0;
    e.opId       = 0;
    if (b == 64'd0) begin
      e.quot    = 64'hFFFF_FFFF_FFFF_FFFF;
      e.rem     = a;
      e.latency = 1;
    end else if (s1 && s2 && a == 64'h8000_0000_0000_0000 &&
                 b == 64'hFFFF_FFFF_FFFF_FFFF) begin
      e.quot    = a;
      e.rem     = 64'd0;
      e.latency = 1;
    end else begin
      q65       = sa / sbv;
      r65       = sa % sbv;
      e.quot    = q65[63:0];
      e.rem     = r65[63:0];
      e.latency = 65;
    end
    return e;
  endfunction

  // Drives one request at a negedge, pushes its expectation, then on the next
  // negedge drops sel and scrambles the operands to prove they were captured.
  task automatic applyStimulus(input logic s1, input logic s2,
                               input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e = computeExpected(s1, s2, a, b);
    rs1_signed   = s1;
    rs2_signed   = s2;
    rs1_data     = a;
    rs2_data     = b;
    sel          = 1'b1;
    lastStart    = cycleCount;
    e.startCycle = cycleCount;
    e.opId       = opCounter;
    opCounter++;
    sb.push_back(e);
    @(negedge clk);
    sel        = 1'b0;
    rs1_data   = {$urandom, $urandom};
    rs2_data   = {$urandom, $urandom};
    rs1_signed = ~s1;
    rs2_signed = ~s2;
  endtask

  // Waits (bounded) until the scoreboard drains, then steps into the idle
  // cycle that follows DONE.
  task automatic waitResult();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 64'(valid), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("op%0d_quot", e.opId), quot_result, e.quot);
        checkOutput($sformatf("op%0d_rem", e.opId), rem_result, e.rem);
        checkOutput($sformatf("op%0d_latency", e.opId),
                    64'(cycleCount - e.startCycle), 64'(e.latency));
      end
    end
  end

  initial begin
    logic        s1;
    logic        s2;
    logic [63:0] a;
    logic [63:0] b;
    rst        = 1'b1;
    sel        = 1'b0;
    flush      = 1'b0;
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    rs1_data   = 64'd0;
    rs2_data   = 64'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_valid", 64'(valid), 64'd0);
    checkOutput("reset_quot", quot_result, 64'd0);
    checkOutput("reset_rem", rem_result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned 100/7 with busy window checks at T+1, T+64, T+65, T+66.
    applyStimulus(1'b0, 1'b0, 64'd100, 64'd7);
    checkOutput("busy_t1", 64'(busy), 64'd1);
    repeat (63) @(negedge clk);
    checkOutput("busy_t64", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("busy_t65", 64'(busy), 64'd1);
    @(negedge clk);
    checkOutput("busy_t66", 64'(busy), 64'd0);
    waitResult();

    // Signed sign combinations, back-to-back after DONE.
    applyStimulus(1'b1, 1'b1, -64'sd7, 64'd2);
    waitResult();
    applyStimulus(1'b1, 1'b1, 64'd7, -64'sd2);
    waitResult();

    // Divide by zero and signed overflow special cases.
    applyStimulus(1'b0, 1'b0, 64'h1234, 64'd0);
    waitResult();
    applyStimulus(1'b1, 1'b1, 64'h1234, 64'd0);
    waitResult();
    applyStimulus(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    waitResult();
    applyStimulus(1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    waitResult();

    // Flush mid-operation with sel pulses while busy, then 9/3 right after.
    applyStimulus(1'b0, 1'b0, 64'd1000, 64'd7);
    rs1_data = 64'd5;
    rs2_data = 64'd1;
    sel      = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    while (cycleCount < lastStart + 30) @(negedge clk);
    flush = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 64'd9, 64'd3);
    waitResult();

    // sel together with flush while idle is dropped.
    rs1_data = 64'd50;
    rs2_data = 64'd5;
    sel      = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    sel   = 1'b0;
    flush = 1'b0;
    checkOutput("sel_flush_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("sel_flush_quot_held", quot_result, 64'd3);

    // Reset at T+10 abandons the operation and clears the outputs.
    applyStimulus(1'b1, 1'b0, -64'sd1000, 64'd13);
    while (cycleCount < lastStart + 10) @(negedge clk);
    rst = 1'b1;
    sel = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_valid", 64'(valid), 64'd0);
    checkOutput("midrst_quot", quot_result, 64'd0);
    checkOutput("midrst_rem", rem_result, 64'd0);
    applyStimulus(1'b0, 1'b1, 64'd123456789, -64'sd1000);
    waitResult();

    // Random operands and signedness, back-to-back.
    for (int i = 0; i < 16; i++) begin
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      case (i % 4)
        0: b = 64'($urandom_range(1, 20));
        1: b = {32'd0, $urandom};
        2: b = -64'($urandom_range(1, 20));
        default: b = {$urandom, $urandom};
      endcase
      applyStimulus(s1, s2, a, b);
      waitResult();
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/radix2_div.md
RADIX2_DIV -- requirements
Module: radix2_div

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port: rs1_signed  input  1  dividend is two's-complement when 1, unsigned when 0.
REQ-004 SHALL have port: rs2_signed  input  1  divisor is two's-complement when 1, unsigned when 0.
REQ-005 SHALL have port: rs1_data  input  64 (REG_BUS)  dividend.
REQ-006 SHALL have port: rs2_data  input  64 (REG_BUS)  divisor.
REQ-007 SHALL have port: sel  input  1  start request; sampled only in IDLE.
REQ-008 SHALL have port: flush  input  1  abort the operation in progress.
REQ-009 SHALL have port: busy  output  1  high while an operation is in progress (not IDLE).
REQ-010 SHALL have port: valid  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port: quot_result  output  64 (REG_BUS)  quotient.
REQ-012 SHALL have port: rem_result  output  64 (REG_BUS)  remainder.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on sel (normal case); IDLE->DONE on sel (special case); CALC->DONE after 64 iterations; DONE->IDLE unconditionally.
REQ-014 SHALL capture rs1_data, rs2_data, rs1_signed, rs2_signed in the cycle sel is accepted; later input changes SHALL have no effect.
REQ-015 SHALL, at capture, convert signed negative operands to magnitude and record quotient sign (signs differ) and remainder sign (dividend sign).
REQ-016 SHALL perform restoring radix-2 division on magnitudes: 128-bit {rem,quot} shift register, one bit per cycle, 65-bit trial subtract, iteration counter 0..63.
REQ-017 SHALL, in the DONE entry cycle, negate quotient/remainder per recorded signs and register them onto quot_result/rem_result.
REQ-018 SHALL assert valid for exactly the one DONE cycle; normal-case latency: sel accepted in cycle T -> valid in cycle T+65.
REQ-019 SHALL treat divisor==0 as special: quot_result=all ones, rem_result=rs1_data unchanged, valid in cycle T+1.
REQ-020 SHALL treat signed overflow (rs1_signed & rs2_signed, rs1=0x8000_0000_0000_0000, rs2=all ones) as special: quot_result=rs1_data, rem_result=0, valid in cycle T+1.
REQ-021 SHALL ignore sel while busy is high; no queueing.
REQ-022 SHALL, on flush in any state, return to IDLE next cycle with valid low that cycle and no later valid for the aborted operation.
REQ-023 SHALL give flush priority over sel in the same cycle; the sel is dropped.
REQ-024 SHALL accept a new sel in the cycle immediately after DONE (back-to-back), and in the cycle after a flush.
REQ-025 SHALL hold quot_result/rem_result stable from valid until the next DONE entry.
REQ-026 SHALL, in the unsigned case (sign flag 0), treat bit 63 as magnitude with no negation; *W variants are formed by the caller (extended operands, sign-extended result).

Reset
REQ-027 SHALL, with rst high at a clock edge, enter IDLE and drive valid=0, busy=0, quot_result=0, rem_result=0, counter=0.
REQ-028 SHALL, on reset mid-operation, abandon the operation with no valid pulse afterwards; rst SHALL override sel and flush.

Verification
REQ-029 SHALL cover: unsigned 100/7, sel at T -> valid at T+65, quot=14, rem=2, busy high T+1..T+65.
REQ-030 SHALL cover: signed -7/2 -> quot=0xFFFF_FFFF_FFFF_FFFD, rem=0xFFFF_FFFF_FFFF_FFFF; signed 7/-2 -> quot=-3, rem=1.
REQ-031 SHALL cover: 0x1234/0 (unsigned and signed) -> valid at T+1, quot=0xFFFF_FFFF_FFFF_FFFF, rem=0x1234.
REQ-032 SHALL cover: signed 0x8000_0000_0000_0000 / -1 -> valid at T+1, quot=0x8000_0000_0000_0000, rem=0; unsigned same operands -> quot=0, rem=0x8000_0000_0000_0000 at T+65.
REQ-033 SHALL cover: flush at T+30 -> no valid; sel at T+31 with 9/3 -> quot=3, rem=0 at T+96; sel pulses during busy ignored.
REQ-034 SHALL cover: rst at T+10 of an operation -> outputs zero, no valid; sel right after reset completes normally; random signed/unsigned operands checked against reference model.
